// File: rtl/warpv_byte_streamer.sv
// warpv_byte_streamer: chip-to-host byte streaming port for tt_um_warpv.
// The core pushes 32-bit words into a DEPTH-entry FIFO. The FSM sends each
// word on uo_data one byte at a time, least significant byte first.
// Each byte is qualified by a 4-phase strb/ack handshake.
// Optional build macro: WARPV_STREAM_HDR_EN. When defined, a 0xA5 header
// byte is sent before the four data bytes of every word.
//
// Handshake semantics:
//   - Write side: a word is accepted on any rising edge where
//     wr_valid && wr_ready. wr_ready depends only on the FIFO count, never
//     on wr_valid.
//   - Host side: strb rises with a byte already stable on uo_data. The host
//     raises ack, and strb then falls. The host drops ack, and only then is
//     the next byte (or idle) presented.
//   - ack is synchronised through two flops. Only the synchronised copy is
//     used.
module warpv_byte_streamer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        wr_valid,
  input  logic [31:0] wr_data,
  output logic        wr_ready,
  output logic [7:0]  uo_data,
  output logic        strb,
  input  logic        ack,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

`ifdef WARPV_STREAM_HDR_EN
  localparam int NBYTES = 5;
`else
  localparam int NBYTES = 4;
`endif
  localparam logic [2:0] LAST_IDX = 3'(NBYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  idx, idx_nxt;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;
  logic [31:0]   head;
  logic [7:0]    cur_byte;

  logic ack_m, ack_s;

  // Two-flop synchroniser for the host acknowledge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= ack;
      ack_s <= ack_m;
    end
  end

  assign wr_ready = (count != FULL_COUNT);
  assign push     = wr_valid && wr_ready;
  assign head     = mem[rd_ptr];

  // FIFO storage. It needs no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers and occupancy. A push and a pop together cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // State and byte-index register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= 3'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state logic. The head is popped only when the last byte's ack falls.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ena && (count != '0) && !ack_s) begin
          state_nxt = ST_DRIVE;
          idx_nxt   = 3'd0;
        end
      end
      ST_DRIVE: begin
        if (ack_s) state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!ack_s) begin
          if (idx != LAST_IDX) begin
            idx_nxt   = idx + 3'd1;
            state_nxt = ST_DRIVE;
          end else begin
            idx_nxt   = 3'd0;
            pop       = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        idx_nxt   = 3'd0;
      end
    endcase
  end

  // Select the byte at position idx, in little-endian order after the optional header
  always_comb begin
    cur_byte = 8'h00;
`ifdef WARPV_STREAM_HDR_EN
    case (idx)
      3'd0:    cur_byte = 8'hA5;
      3'd1:    cur_byte = head[7:0];
      3'd2:    cur_byte = head[15:8];
      3'd3:    cur_byte = head[23:16];
      3'd4:    cur_byte = head[31:24];
      default: cur_byte = 8'h00;
    endcase
`else
    case (idx)
      3'd0:    cur_byte = head[7:0];
      3'd1:    cur_byte = head[15:8];
      3'd2:    cur_byte = head[23:16];
      3'd3:    cur_byte = head[31:24];
      default: cur_byte = 8'h00;
    endcase
`endif
  end

  // Outputs decoded from the state. The head entry cannot change while a
  // word is in flight, so uo_data changes only when strb rises or on the
  // return to idle.
  always_comb begin
    strb    = (state == ST_DRIVE);
    uo_data = (state == ST_IDLE) ? 8'h00 : cur_byte;
    busy    = (state != ST_IDLE) || (count != '0);
  end

endmodule
